sync_multi_filt: RTL and testbench

//  Multi-channel, parametrised input synchronizer for asynchronous pins (buttons, strobes, handshakes).

---
 rtl/sync_pkg.sv | 14 +
 rtl/sync_chan.sv | 66 ++++++
 rtl/sync_multi_filt.sv | 47 ++++
 tb/tb_sync_multi_filt.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel input synchronizer.
package sync_pkg;

   // Fewer than two flops gives no real metastability settling time.
   localparam int SYNC_MIN_STAGES = 2;

   // Width of a counter that must hold values 0..n; never narrower than 1 bit.
   function automatic int cnt_width(int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sync_chan.sv
// One synchronizer channel: flop chain, optional glitch filter, edge detect.
module sync_chan
   import sync_pkg::*;
#(
   parameter int   STAGES   = 2,
   parameter logic RST_BIT  = 1'b0,
   parameter int   FILT_CNT = 3
) (
   input  logic clk,
   input  logic n_rst,
   input  logic async_in,
   output logic sync_out,
   output logic filt_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   logic [STAGES-1:0] chain;
   logic              filt_prev;

   // Synchronizer chain; async_in only ever lands in bit 0.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) chain <= {STAGES{RST_BIT}};
      else        chain <= {chain[STAGES-2:0], async_in};
   end

   assign sync_out = chain[STAGES-1];

   if (FILT_CNT == 0) begin : g_bypass
      assign filt_out = sync_out;
   end else begin : g_filt
      localparam int             CW       = cnt_width(FILT_CNT);
      localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CNT - 1);

      logic [CW-1:0] cnt;
      logic          filt_q;

      // Filtered level moves only after FILT_CNT consecutive differing samples;
      // any agreeing sample restarts the qualification from zero.
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            cnt    <= '0;
            filt_q <= RST_BIT;
         end else if (sync_out == filt_q) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            filt_q <= sync_out;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign filt_out = filt_q;
   end

   // Previous filtered level, for one-cycle edge pulses.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) filt_prev <= RST_BIT;
      else        filt_prev <= filt_out;
   end

   assign rise_pulse =  filt_out & ~filt_prev;
   assign fall_pulse = ~filt_out &  filt_prev;

endmodule

// File: rtl/sync_multi_filt.sv
// Multi-channel synchronizer with glitch filter and edge pulses for async pins.
module sync_multi_filt
   import sync_pkg::*;
#(
   parameter int               NUM_CH   = 4,
   parameter int               STAGES   = 2,
   parameter logic [NUM_CH-1:0] RST_VAL = '0,
   parameter int               FILT_CNT = 3
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [NUM_CH-1:0] async_in,
   output logic [NUM_CH-1:0] sync_out,
   output logic [NUM_CH-1:0] filt_out,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse
);

   // Reject configurations that cannot work, at elaboration time.
   if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
      $error("sync_multi_filt: STAGES=%0d below minimum %0d", STAGES, SYNC_MIN_STAGES);
   end
   if (NUM_CH < 1) begin : g_bad_ch
      $error("sync_multi_filt: NUM_CH must be at least 1");
   end
   if (FILT_CNT < 0) begin : g_bad_filt
      $error("sync_multi_filt: FILT_CNT must not be negative");
   end

   // Channels are fully independent copies.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sync_chan #(
         .STAGES   (STAGES),
         .RST_BIT  (RST_VAL[i]),
         .FILT_CNT (FILT_CNT)
      ) u_chan (
         .clk        (clk),
         .n_rst      (n_rst),
         .async_in   (async_in[i]),
         .sync_out   (sync_out[i]),
         .filt_out   (filt_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i])
      );
   end

endmodule

// File: tb/tb_sync_multi_filt.sv
// Bench for sync_multi_filt: three configurations driven in parallel and
// checked every cycle against a history-window model, plus literal anchors.
module tb_sync_multi_filt;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [3:0] ain;
   logic [3:0] so[3], fo[3], rp[3], fp[3];

   int checks   = 0;
   int failures = 0;

   // Configurations: 0 = reset pattern 0101, 1 = bypass with 3 stages, 2 = defaults.
   int         st_p[3] = '{2, 3, 2};
   int         fc_p[3] = '{3, 0, 3};
   logic [3:0] rv_p[3] = '{4'b0101, 4'b0000, 4'b0000};

   always #5 clk = ~clk;

   sync_multi_filt #(.NUM_CH(4), .STAGES(2), .RST_VAL(4'b0101), .FILT_CNT(3)) dut_a (
      .clk(clk), .n_rst(n_rst), .async_in(ain),
      .sync_out(so[0]), .filt_out(fo[0]), .rise_pulse(rp[0]), .fall_pulse(fp[0]));

   sync_multi_filt #(.NUM_CH(4), .STAGES(3), .RST_VAL(4'b0000), .FILT_CNT(0)) dut_b (
      .clk(clk), .n_rst(n_rst), .async_in(ain),
      .sync_out(so[1]), .filt_out(fo[1]), .rise_pulse(rp[1]), .fall_pulse(fp[1]));

   sync_multi_filt dut_c (
      .clk(clk), .n_rst(n_rst), .async_in(ain),
      .sync_out(so[2]), .filt_out(fo[2]), .rise_pulse(rp[2]), .fall_pulse(fp[2]));

   // ---------------- model ----------------
   // hin[d][k]: async_in captured k+1 edges ago. hs[d][k]: sync value seen
   // just before the edge k edges ago (k=0 most recent).
   logic [3:0] hin[3][8];
   logic [3:0] hs[3][8];
   logic [3:0] mf[3];
   logic [3:0] mp[3];

   function automatic logic [3:0] m_sync(int d);
      return hin[d][st_p[d]-1];
   endfunction

   function automatic logic [3:0] m_filt(int d);
      return (fc_p[d] == 0) ? m_sync(d) : mf[d];
   endfunction

   task automatic m_reset();
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 8; k++) begin
            hin[d][k] = rv_p[d];
            hs[d][k]  = rv_p[d];
         end
         mf[d] = rv_p[d];
         mp[d] = rv_p[d];
      end
   endtask

   task automatic m_step();
      logic [3:0] s, f, nf;
      bit         all_diff;
      for (int d = 0; d < 3; d++) begin
         s = m_sync(d);
         f = m_filt(d);
         for (int k = 7; k > 0; k--) hs[d][k] = hs[d][k-1];
         hs[d][0] = s;
         if (fc_p[d] > 0) begin
            // A level change is accepted when the last FILT_CNT samples all disagree.
            nf = f;
            for (int c = 0; c < 4; c++) begin
               all_diff = 1'b1;
               for (int k = 0; k < fc_p[d]; k++)
                  if (hs[d][k][c] == f[c]) all_diff = 1'b0;
               if (all_diff) nf[c] = ~f[c];
            end
            mf[d] = nf;
         end
         mp[d] = f;
         for (int k = 7; k > 0; k--) hin[d][k] = hin[d][k-1];
         hin[d][0] = ain;
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge n_rst);
         if (!n_rst) m_reset();
         else        m_step();
      end
   end

   // ---------------- checking ----------------
   task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every configuration against the model.
   initial begin
      logic [3:0] ef;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            ef = m_filt(d);
            chk($sformatf("model_sync[%0d]", d), so[d], m_sync(d));
            chk($sformatf("model_filt[%0d]", d), fo[d], ef);
            chk($sformatf("model_rise[%0d]", d), rp[d], ef & ~mp[d]);
            chk($sformatf("model_fall[%0d]", d), fp[d], ~ef & mp[d]);
            chk($sformatf("rise_fall_excl[%0d]", d), rp[d] & fp[d], 4'b0000);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      logic [3:0] flip;
      n_rst = 1'b0;
      ain   = 4'b0000;
      step(3);
      // Reset values
      chk("rst_sync_a", so[0], 4'b0101);
      chk("rst_filt_a", fo[0], 4'b0101);
      chk("rst_pulse_a", rp[0] | fp[0], 4'b0000);
      chk("rst_sync_c", so[2], 4'b0000);
      n_rst = 1'b1;
      step(1);
      chk("no_pulse_after_release", rp[0] | fp[0], 4'b0000);
      step(10);

      // Latency on defaults, channel 0
      ain = 4'b0001;
      step(2);
      chk("lat_sync_2", so[2], 4'b0001);
      step(2);
      chk("lat_filt_4", fo[2], 4'b0000);
      step(1);
      chk("lat_filt_5", fo[2], 4'b0001);
      chk("lat_rise_5", rp[2], 4'b0001);
      step(1);
      chk("lat_rise_6", rp[2], 4'b0000);

      // Glitch on channel 1: two cycles rejected, three accepted
      ain = 4'b0011;
      step(2);
      ain = 4'b0001;
      step(8);
      chk("glitch_reject", fo[2], 4'b0001);
      ain = 4'b0011;
      step(3);
      ain = 4'b0001;
      step(2);
      chk("glitch_accept_filt", fo[2], 4'b0011);
      chk("glitch_accept_rise", rp[2], 4'b0010);
      step(10);

      // Bypass, 3 stages, channel 2
      ain = 4'b0101;
      step(2);
      chk("byp_sync_2", so[1], 4'b0001);
      step(1);
      chk("byp_filt_3", fo[1], 4'b0101);
      chk("byp_rise_3", rp[1], 4'b0100);
      step(1);
      chk("byp_rise_4", rp[1], 4'b0000);
      ain = 4'b0001;
      step(3);
      chk("byp_fall_3", fp[1], 4'b0100);
      step(1);

      // Simultaneous change on all channels
      ain = 4'b0000;
      step(10);
      ain = 4'b1111;
      step(5);
      chk("simul_rise", rp[2], 4'b1111);
      step(1);
      chk("simul_rise_end", rp[2], 4'b0000);
      ain = 4'b0000;
      step(5);
      chk("simul_fall", fp[2], 4'b1111);
      step(1);
      chk("simul_fall_end", fp[2], 4'b0000);
      step(5);

      // Reset in the middle of a qualification
      ain = 4'b1000;
      step(4);
      n_rst = 1'b0;
      #1;
      chk("midrst_filt_c", fo[2], 4'b0000);
      chk("midrst_filt_a", fo[0], 4'b0101);
      chk("midrst_sync_a", so[0], 4'b0101);
      step(1);
      n_rst = 1'b1;
      step(4);
      chk("midrst_requal_4", fo[2], 4'b0000);
      step(1);
      chk("midrst_requal_5", fo[2], 4'b1000);

      // Randomized phase: sparse bit flips so both short glitches and long holds occur
      for (int i = 0; i < 600; i++) begin
         flip = 4'b0000;
         for (int c = 0; c < 4; c++)
            if ($urandom_range(0, 3) == 0) flip[c] = 1'b1;
         ain = ain ^ flip;
         if ($urandom_range(0, 99) == 0) begin
            n_rst = 1'b0;
            step($urandom_range(1, 2));
            n_rst = 1'b1;
         end else begin
            step(1);
         end
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
